// File: rtl/demux8_deser_if.sv
// Signal bundle between the upstream serial source and the demux8_deser
// deserializer: serial input side plus the parallel result and status.
interface demux8_deser_if #(
    parameter int N  = 8,
    parameter int SW = 3
);
    logic          start;
    logic          in_valid;
    logic          d_in;
    logic          mode;
    logic [SW-1:0] s;
    logic [N-1:0]  y;
    logic          out_valid;
    logic          busy;
    logic [SW-1:0] idx;

    modport master (
        output start, in_valid, d_in, mode, s,
        input  y, out_valid, busy, idx
    );

    modport slave (
        input  start, in_valid, d_in, mode, s,
        output y, out_valid, busy, idx
    );
endinterface

// File: rtl/demux8_deser.sv
// Serial-to-parallel demultiplexer: rebuilds the d0..d(N-1) vector from a
// serial stream using an internal scan counter (auto) or external select (direct).
module demux8_deser #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic           clk,
    input  logic           reset,
    demux8_deser_if.slave  bus
);
    typedef enum logic {IDLE, COLLECT} state_t;

    state_t        state_q, state_d;
    // The last slot bypasses the shadow and lands directly in y.
    logic [N-2:0]  shadow_q, shadow_d;
    logic [N-1:0]  y_q, y_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] idx_q, idx_d;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        y_d         = y_q;
        out_valid_d = 1'b0;
        idx_d       = idx_q;

        if (bus.mode) begin
            if (bus.in_valid) begin
                y_d[bus.s] = bus.d_in;
            end
            if (state_q == COLLECT) begin
                state_d = IDLE;
                idx_d   = '0;
            end
        end else if (bus.start) begin
            // A start in COLLECT restarts the frame; stale shadow bits get overwritten.
            state_d = COLLECT;
            if (bus.in_valid) begin
                shadow_d[0] = bus.d_in;
                idx_d       = SW'(1);
            end else begin
                idx_d = '0;
            end
        end else if (state_q == COLLECT && bus.in_valid) begin
            if (idx_q == SW'(N - 1)) begin
                y_d         = {bus.d_in, shadow_q};
                out_valid_d = 1'b1;
                idx_d       = '0;
                state_d     = IDLE;
            end else begin
                shadow_d[idx_q] = bus.d_in;
                idx_d           = idx_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q == COLLECT);
    assign bus.idx       = idx_q;
endmodule

// File: tb/tb_demux8_deser.sv
// Bench for demux8_deser: per-cycle vector table through a scoreboard queue,
// then random auto-mode frames with bounded waits for out_valid.
module tb_demux8_deser;
    logic clk;
    logic reset;

    demux8_deser_if #(.N(8), .SW(3)) bus ();

    demux8_deser #(.N(8), .SW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst, st, iv, d, md;
        logic [2:0] s;
        logic [7:0] y;
        logic       ov, busy;
        logic [2:0] idx;
    } vec_t;

    vec_t       vecs[$];
    vec_t       sb[$];
    logic [7:0] frame_sb[$];
    int         total = 0;
    int         bad   = 0;

    function automatic void add(string nm, logic rst, logic st, logic iv, logic d,
                                logic md, logic [2:0] s, logic [7:0] y, logic ov,
                                logic b, logic [2:0] idx);
        vec_t v;
        v.name = nm; v.rst = rst; v.st = st; v.iv = iv; v.d = d; v.md = md;
        v.s = s; v.y = y; v.ov = ov; v.busy = b; v.idx = idx;
        vecs.push_back(v);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic st, logic iv, logic d, logic md, logic [2:0] s);
        reset = rst; bus.start = st; bus.in_valid = iv; bus.d_in = d;
        bus.mode = md; bus.s = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] bits;
        logic [7:0] got;
        logic [7:0] want;
        logic       seen;

        reset = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0; bus.d_in = 1'b0;
        bus.mode = 1'b0; bus.s = '0;

        // reset with start/in_valid asserted
        add("rst0", 1,1,1,1,0,0, 8'h00,0,0,0);
        add("rst1", 1,1,1,1,0,0, 8'h00,0,0,0);
        add("idle", 0,0,0,0,0,0, 8'h00,0,0,0);
        add("iv_no_start", 0,0,1,1,0,0, 8'h00,0,0,0);
        // auto frame 1,0,1,1,0,0,1,0
        add("af0", 0,1,1,1,0,0, 8'h00,0,1,1);
        add("af1", 0,0,1,0,0,0, 8'h00,0,1,2);
        add("af2", 0,0,1,1,0,0, 8'h00,0,1,3);
        add("af3", 0,0,1,1,0,0, 8'h00,0,1,4);
        add("af4", 0,0,1,0,0,0, 8'h00,0,1,5);
        add("af5", 0,0,1,0,0,0, 8'h00,0,1,6);
        add("af6", 0,0,1,1,0,0, 8'h00,0,1,7);
        add("af7", 0,0,1,0,0,0, 8'h4D,1,0,0);
        add("af_after", 0,0,0,0,0,0, 8'h4D,0,0,0);
        // gapped frame, 3 idle cycles after bit 4
        add("gf0", 0,1,1,1,0,0, 8'h4D,0,1,1);
        add("gf1", 0,0,1,0,0,0, 8'h4D,0,1,2);
        add("gf2", 0,0,1,1,0,0, 8'h4D,0,1,3);
        add("gf3", 0,0,1,1,0,0, 8'h4D,0,1,4);
        add("gf4", 0,0,1,0,0,0, 8'h4D,0,1,5);
        add("gap0", 0,0,0,1,0,0, 8'h4D,0,1,5);
        add("gap1", 0,0,0,1,0,0, 8'h4D,0,1,5);
        add("gap2", 0,0,0,1,0,0, 8'h4D,0,1,5);
        add("gf5", 0,0,1,0,0,0, 8'h4D,0,1,6);
        add("gf6", 0,0,1,1,0,0, 8'h4D,0,1,7);
        add("gf7", 0,0,1,0,0,0, 8'h4D,1,0,0);
        add("gf_after", 0,0,0,0,0,0, 8'h4D,0,0,0);
        // restart mid-frame: 5 zero bits then a fresh all-ones frame
        add("rs0", 0,1,1,0,0,0, 8'h4D,0,1,1);
        for (int i = 1; i < 5; i++) add("rs_old", 0,0,1,0,0,0, 8'h4D,0,1,3'(i+1));
        add("rs_start", 0,1,1,1,0,0, 8'h4D,0,1,1);
        for (int i = 1; i < 7; i++) add("rs_new", 0,0,1,1,0,0, 8'h4D,0,1,3'(i+1));
        add("rs_last", 0,0,1,1,0,0, 8'hFF,1,0,0);
        add("rs_after", 0,0,0,0,0,0, 8'hFF,0,0,0);
        // direct mode from cleared y
        add("d_rst", 1,0,0,0,0,0, 8'h00,0,0,0);
        add("d_s3", 0,0,1,1,1,3, 8'h08,0,0,0);
        add("d_s7", 0,0,1,1,1,7, 8'h88,0,0,0);
        add("d_s3z", 0,0,1,0,1,3, 8'h80,0,0,0);
        add("d_start_ign", 0,1,0,1,1,5, 8'h80,0,0,0);
        // mode abort after 4 bits
        add("ma0", 0,1,1,0,0,0, 8'h80,0,1,1);
        add("ma1", 0,0,1,0,0,0, 8'h80,0,1,2);
        add("ma2", 0,0,1,0,0,0, 8'h80,0,1,3);
        add("ma3", 0,0,1,0,0,0, 8'h80,0,1,4);
        add("ma_abort", 0,0,1,1,1,0, 8'h81,0,0,0);
        add("ma_back", 0,0,0,0,0,0, 8'h81,0,0,0);
        // reset mid-frame after 4 bits
        add("rm0", 0,1,1,1,0,0, 8'h81,0,1,1);
        add("rm1", 0,0,1,1,0,0, 8'h81,0,1,2);
        add("rm2", 0,0,1,1,0,0, 8'h81,0,1,3);
        add("rm3", 0,0,1,1,0,0, 8'h81,0,1,4);
        add("rm_reset", 1,1,1,1,0,0, 8'h00,0,0,0);
        add("rm_idle", 0,0,0,0,0,0, 8'h00,0,0,0);

        foreach (vecs[i]) begin
            sb.push_back(vecs[i]);
            drive(vecs[i].rst, vecs[i].st, vecs[i].iv, vecs[i].d, vecs[i].md, vecs[i].s);
            begin
                vec_t e;
                e = sb.pop_front();
                check({e.name, ".y"},         32'(bus.y),         32'(e.y));
                check({e.name, ".out_valid"}, 32'(bus.out_valid), 32'(e.ov));
                check({e.name, ".busy"},      32'(bus.busy),      32'(e.busy));
                check({e.name, ".idx"},       32'(bus.idx),       32'(e.idx));
            end
        end

        // random auto frames with random gaps
        for (int f = 0; f < 6; f++) begin
            bits = 8'($urandom_range(0, 255));
            frame_sb.push_back(bits);
            for (int i = 0; i < 8; i++) begin
                if (i > 0 && $urandom_range(0, 3) == 0) begin
                    drive(0, 0, 0, 1'b1, 0, 0);
                    check("rnd_gap_idx", 32'(bus.idx), 32'(i));
                end
                drive(0, (i == 0), 1'b1, bits[i], 0, 0);
                if (i < 7) check("rnd_no_ov", 32'(bus.out_valid), 32'(0));
            end
            seen = bus.out_valid;
            got  = bus.y;
            for (int w = 0; w < 4 && !seen; w++) begin
                drive(0, 0, 0, 0, 0, 0);
                seen = bus.out_valid;
                got  = bus.y;
            end
            if (!seen) begin
                total++;
                bad++;
                $display("FAIL rnd_timeout: out_valid not seen, expected frame %0h", bits);
                void'(frame_sb.pop_front());
            end else begin
                want = frame_sb.pop_front();
                check("rnd_y", 32'(got), 32'(want));
                drive(0, 0, 0, 0, 0, 0);
                check("rnd_ov_pulse", 32'(bus.out_valid), 32'(0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
